load_align_unit: RTL and testbench

- Parametrised, sequential successor to the pipeline's combinational load extractor.
- Accepts a load request (address, access size, signedness) and issues one or two aligned reads to a synchronous data memory.
- Selects and merges the addressed bytes, then sign- or zero-extends them. Returns the result through a valid/ready response port.
- Sits between the MEM-stage control and the DM; supports byte/half/word and, for DATA_W=64, double accesses.

---
 rtl/load_align_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_align_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// load_align_unit: sequential load extractor with aligned DM reads.
// Optional LOAD_SPLIT_EN enables two-read merging of word-crossing loads.
module load_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        CAP0,
        RESP
`ifdef LOAD_SPLIT_EN
        , CAP1
`endif
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
`ifdef LOAD_SPLIT_EN
    logic [DATA_W-1:0] lo_q;
    logic              split_q;
`endif

    logic [4:0]        req_nb;
    logic [4:0]        req_end;
    logic              req_illegal;
    logic              req_split;
    logic              req_fail;
    logic              accept;
    logic              load_done;

    logic [ADDR_W-1:0]   aligned;
    logic [2*DATA_W-1:0] wide;
    logic [DATA_W-1:0]   kept;
    logic [DATA_W-1:0]   mask;
    logic [DATA_W-1:0]   topbit;
    logic [DATA_W-1:0]   result;
    logic [6:0]          nbits;
    logic                sign;

    assign accept    = req_valid && req_ready;
    assign req_ready = rst_n && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign aligned   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Classify the incoming request: illegal size, word crossing.
    always_comb begin
        req_nb      = 5'd1 << req_size;
        req_end     = 5'(req_addr[OFF_W-1:0]) + req_nb;
        req_illegal = req_nb > 5'(BYTES);
        req_split   = req_end > 5'(BYTES);
`ifdef LOAD_SPLIT_EN
        req_fail    = req_illegal;
`else
        req_fail    = req_illegal || req_split;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and state-decoded memory strobes.
    always_comb begin
        state_nx  = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        load_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = req_fail ? RESP : ISSUE0;
                end
            end
            ISSUE0: begin
                mem_rd_en = 1'b1;
                mem_addr  = aligned;
                state_nx  = CAP0;
            end
            CAP0: begin
`ifdef LOAD_SPLIT_EN
                if (split_q) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = aligned + ADDR_W'(BYTES);
                    state_nx  = CAP1;
                end else begin
                    load_done = 1'b1;
                    state_nx  = RESP;
                end
`else
                load_done = 1'b1;
                state_nx  = RESP;
`endif
            end
`ifdef LOAD_SPLIT_EN
            CAP1: begin
                load_done = 1'b1;
                state_nx  = RESP;
            end
`endif
            RESP: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Merge, shift to the addressed byte, then extend.
    always_comb begin
`ifdef LOAD_SPLIT_EN
        if (state == CAP1) begin
            wide = {mem_rdata, lo_q};
        end else begin
            wide = {{DATA_W{1'b0}}, mem_rdata};
        end
`else
        wide = {{DATA_W{1'b0}}, mem_rdata};
`endif
        kept   = DATA_W'(wide >> {addr_q[OFF_W-1:0], 3'b000});
        nbits  = 7'd8 << size_q;
        topbit = kept >> (nbits - 7'd1);
        sign   = topbit[0] && !uns_q;
        mask   = '0;
        result = kept;
        if (nbits < 7'(DATA_W)) begin
            mask   = ~({DATA_W{1'b1}} << nbits);
            result = (kept & mask) | (sign ? ~mask : '0);
        end
    end

    // Request capture and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b0;
`ifdef LOAD_SPLIT_EN
            lo_q      <= '0;
            split_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                size_q <= req_size;
                uns_q  <= req_unsigned;
`ifdef LOAD_SPLIT_EN
                split_q <= req_split;
`endif
                if (req_fail) begin
                    resp_data <= '0;
                    resp_err  <= 1'b1;
                end
            end
`ifdef LOAD_SPLIT_EN
            if (state == CAP0) begin
                lo_q <= mem_rdata;
            end
`endif
            if (load_done) begin
                resp_data <= result;
                resp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: random and directed loads on 32- and 64-bit units.
// Checks data, error, latency and DM read sequence against a byte model.
module tb_load_align_unit;

`ifdef LOAD_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_ready;

    logic        rqr32, rd32, rv32, re32;
    logic [31:0] ma32, rdata32, rdat32;
    logic        rqr64, rd64, rv64, re64;
    logic [31:0] ma64;
    logic [63:0] rdata64, rdat64;

    logic        obs_ready, obs_rd, obs_rv, obs_err;
    logic [31:0] obs_ma;
    logic [63:0] obs_data;

    logic [7:0]  bmem [0:255];

    int nchk;
    int nerr;

    load_align_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && !sel), .req_ready(rqr32),
        .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .mem_rd_en(rd32), .mem_addr(ma32), .mem_rdata(rdata32),
        .resp_valid(rv32), .resp_ready(resp_ready),
        .resp_data(rdat32), .resp_err(re32)
    );

    load_align_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel), .req_ready(rqr64),
        .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .mem_rd_en(rd64), .mem_addr(ma64), .mem_rdata(rdata64),
        .resp_valid(rv64), .resp_ready(resp_ready),
        .resp_data(rdat64), .resp_err(re64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memories, one word port per unit.
    always @(posedge clk) begin
        if (rd32) begin
            for (int i = 0; i < 4; i++)
                rdata32[8*i +: 8] <= bmem[ma32[7:0] + 8'(i)];
        end
        if (rd64) begin
            for (int i = 0; i < 8; i++)
                rdata64[8*i +: 8] <= bmem[ma64[7:0] + 8'(i)];
        end
    end

    always_comb begin
        if (sel) begin
            obs_ready = rqr64; obs_rd = rd64; obs_rv = rv64;
            obs_err = re64; obs_ma = ma64; obs_data = rdat64;
        end else begin
            obs_ready = rqr32; obs_rd = rd32; obs_rv = rv32;
            obs_err = re32; obs_ma = ma32; obs_data = {32'h0, rdat32};
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: gather nbytes little-endian from the byte store, extend.
    function automatic logic [64:0] model(input logic [31:0] a,
                                          input logic [1:0] sz,
                                          input bit uns, input int w);
        int bytes = w / 8;
        int nb = 1 << sz;
        int off = int'(a % bytes);
        logic [63:0] v = '0;
        if (nb > bytes) return {1'b1, 64'h0};
        if (off + nb > bytes && !SPLIT) return {1'b1, 64'h0};
        for (int i = 0; i < nb; i++)
            v = v | (64'(bmem[8'(a + 32'(i))]) << (8 * i));
        if (nb * 8 < w && !uns && v[nb*8-1])
            v = v | (~64'h0 << (nb * 8));
        if (w == 32) v = v & 64'hFFFF_FFFF;
        return {1'b0, v};
    endfunction

    task automatic run_load(input bit w64, input logic [31:0] a,
                            input logic [1:0] sz, input bit uns,
                            input int hold);
        int bytes = w64 ? 8 : 4;
        logic [64:0] m = model(a, sz, uns, w64 ? 64 : 32);
        bit err = m[64];
        int nb = 1 << sz;
        bit split = !err && (int'(a % bytes) + nb > bytes);
        int exp_lat = err ? 1 : (split ? 4 : 3);
        int exp_nrd = err ? 0 : (split ? 2 : 1);
        logic [31:0] al = a & ~32'(bytes - 1);
        int lat = 0;
        int nrd = 0;
        logic [31:0] ra [2];
        int rk [2];
        logic [63:0] held;
        ra[0] = '0; ra[1] = '0; rk[0] = 0; rk[1] = 0;
        sel = w64;
        resp_ready = (hold == 0);
        req_addr = a;
        req_size = sz;
        req_unsigned = uns;
        req_valid = 1'b1;
        #1;
        check("req_ready_idle", 64'(obs_ready), 64'h1);
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (obs_rd) begin
                if (nrd < 2) begin
                    ra[nrd] = obs_ma;
                    rk[nrd] = k;
                end
                nrd++;
            end
            if (obs_rv) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("nreads", 64'(nrd), 64'(exp_nrd));
        check("data", obs_data, m[63:0]);
        check("err", 64'(obs_err), 64'(err));
        if (exp_nrd > 0) check("rd_addr0", 64'(ra[0]), 64'(al));
        if (split) begin
            check("rd_addr1", 64'(ra[1]), 64'(al + 32'(bytes)));
            check("rd_gap", 64'(rk[1] - rk[0]), 64'h1);
        end
        held = obs_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(obs_rv), 64'h1);
            check("hold_data", obs_data, held);
            check("hold_ready", 64'(obs_ready), 64'h0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("resp_drop", 64'(obs_rv), 64'h0);
        check("ready_back", 64'(obs_ready), 64'h1);
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        sel = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_size = '0;
        req_unsigned = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 256; i++) bmem[i] = 8'($urandom);
        bmem[0] = 8'h80; bmem[1] = 8'h33; bmem[2] = 8'h22; bmem[3] = 8'h11;
        bmem[4] = 8'hFF; bmem[5] = 8'hEE; bmem[6] = 8'hDD; bmem[7] = 8'hCC;

        repeat (3) @(negedge clk);
        check("rst_ready32", 64'(rqr32), 64'h0);
        check("rst_valid32", 64'(rv32), 64'h0);
        check("rst_rd32", 64'(rd32), 64'h0);
        check("rst_data32", 64'(rdat32), 64'h0);
        check("rst_ready64", 64'(rqr64), 64'h0);
        check("rst_err64", 64'(re64), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(rqr32), 64'h1);

        run_load(1'b0, 32'h100, 2'd0, 1'b0, 0);
        run_load(1'b0, 32'h103, 2'd0, 1'b1, 0);
        run_load(1'b0, 32'h102, 2'd1, 1'b1, 0);
        run_load(1'b0, 32'h101, 2'd1, 1'b0, 0);
        run_load(1'b0, 32'h102, 2'd2, 1'b0, 0);
        run_load(1'b0, 32'h100, 2'd3, 1'b0, 0);
        run_load(1'b0, 32'h100, 2'd2, 1'b0, 5);
        run_load(1'b0, 32'h104, 2'd1, 1'b0, 0);

        sel = 1'b0;
        req_addr = 32'h100;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(rqr32), 64'h0);
        check("midrst_rd", 64'(rd32), 64'h0);
        check("midrst_addr", 64'(ma32), 64'h0);
        check("midrst_valid", 64'(rv32), 64'h0);
        check("midrst_data", 64'(rdat32), 64'h0);
        check("midrst_err", 64'(re32), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_load(1'b0, 32'h104, 2'd0, 1'b0, 0);

        run_load(1'b1, 32'h100, 2'd3, 1'b1, 0);
        run_load(1'b1, 32'h106, 2'd1, 1'b0, 0);

        for (int n = 0; n < 60; n++) begin
            bit w = 1'($urandom);
            logic [31:0] a = 32'h100 + 32'($urandom_range(0, 255));
            logic [1:0] sz = 2'($urandom);
            bit u = 1'($urandom);
            int h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_load(w, a, sz, u, h);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
